// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router sequencing controller:
// state encodings, address field width and port count.
package router_pkg;

    localparam int ADDR_W    = 2;
    localparam int STATE_W   = 3;
    localparam int NUM_PORTS = 3;

    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [STATE_W-1:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } state_e;

endpackage

// File: rtl/router_fsm.sv
// Router sequencing FSM: one packet in flight (header, payload, parity),
// Moore strobes for the input register, port synchronizer and destination FIFOs.
//
// state              | meaning
// -------------------+------------------------------------------------------
// DECODE_ADDRESS     | idle, waiting for a header with a valid destination
// LOAD_FIRST_DATA    | header byte written, one cycle
// LOAD_DATA          | payload bytes streaming into the FIFO
// LOAD_PARITY        | parity byte written
// FIFO_FULL_STATE    | destination FIFO full, input stalled
// LOAD_AFTER_FULL    | flush the byte held while the FIFO was full
// CHECK_PARITY_ERROR | parity compare cycle
// WAIT_TILL_EMPTY    | destination FIFO still draining a previous packet
module router_fsm
    import router_pkg::*;
(
    input  logic              clock,
    input  logic              resetn,
    input  logic              pkt_valid,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic              fifo_empty_0,
    input  logic              fifo_empty_1,
    input  logic              fifo_empty_2,
    input  logic              soft_reset_0,
    input  logic              soft_reset_1,
    input  logic              soft_reset_2,
    input  logic              parity_done,
    input  logic              low_packet_valid,
    output logic              detect_add,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              laf_state,
    output logic              full_state,
    output logic              rst_int_reg,
    output logic              write_enb_reg,
    output logic              busy
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic hdr_empty;
    logic sel_empty;
    logic sel_soft_reset;

    always_comb begin
        hdr_empty = 1'b0;
        case (data_in)
            2'd0:    hdr_empty = fifo_empty_0;
            2'd1:    hdr_empty = fifo_empty_1;
            2'd2:    hdr_empty = fifo_empty_2;
            default: hdr_empty = 1'b0;
        endcase
    end

    // Latched destination steers both the empty flag and the soft reset watched mid-packet.
    always_comb begin
        sel_empty      = 1'b0;
        sel_soft_reset = 1'b0;
        case (addr_q)
            2'd0: begin
                sel_empty      = fifo_empty_0;
                sel_soft_reset = soft_reset_0;
            end
            2'd1: begin
                sel_empty      = fifo_empty_1;
                sel_soft_reset = soft_reset_1;
            end
            2'd2: begin
                sel_empty      = fifo_empty_2;
                sel_soft_reset = soft_reset_2;
            end
            default: begin
                sel_empty      = 1'b0;
                sel_soft_reset = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;

        if (state_q == DECODE_ADDRESS && pkt_valid) begin
            addr_d = data_in;
        end

        if (state_q != DECODE_ADDRESS && sel_soft_reset) begin
            state_d = DECODE_ADDRESS;
        end else begin
            case (state_q)
                DECODE_ADDRESS: begin
                    if (pkt_valid && data_in != ADDR_INVALID) begin
                        state_d = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                    end
                end
                LOAD_FIRST_DATA: state_d = LOAD_DATA;
                LOAD_DATA: begin
                    if (fifo_full)       state_d = FIFO_FULL_STATE;
                    else if (!pkt_valid) state_d = LOAD_PARITY;
                end
                FIFO_FULL_STATE: begin
                    if (!fifo_full) state_d = LOAD_AFTER_FULL;
                end
                LOAD_AFTER_FULL: begin
                    if (parity_done)           state_d = DECODE_ADDRESS;
                    else if (low_packet_valid) state_d = LOAD_PARITY;
                    else                       state_d = LOAD_DATA;
                end
                LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: begin
                    state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                end
                WAIT_TILL_EMPTY: begin
                    if (sel_empty) state_d = LOAD_FIRST_DATA;
                end
                default: state_d = DECODE_ADDRESS;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= DECODE_ADDRESS;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    assign detect_add    = (state_q == DECODE_ADDRESS);
    assign lfd_state     = (state_q == LOAD_FIRST_DATA);
    assign ld_state      = (state_q == LOAD_DATA);
    assign laf_state     = (state_q == LOAD_AFTER_FULL);
    assign full_state    = (state_q == FIFO_FULL_STATE);
    assign rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
    assign write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY) ||
                           (state_q == LOAD_AFTER_FULL);
    assign busy          = !((state_q == DECODE_ADDRESS) || (state_q == LOAD_DATA));

endmodule

// File: tb/tb_router_fsm.sv
// Scoreboard bench for router_fsm: each directed step queues the expected
// output vector, and a negedge monitor pops and compares it.
module tb_router_fsm;

    localparam int S_DA  = 0;
    localparam int S_LFD = 1;
    localparam int S_LD  = 2;
    localparam int S_LP  = 3;
    localparam int S_FF  = 4;
    localparam int S_LAF = 5;
    localparam int S_CPE = 6;
    localparam int S_WTE = 7;

    logic       clock = 1'b0;
    logic       resetn;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic [2:0] fe;
    logic [2:0] sr;
    logic       parity_done;
    logic       low_packet_valid;

    logic detect_add, lfd_state, ld_state, laf_state, full_state;
    logic rst_int_reg, write_enb_reg, busy;

    logic [7:0] exp_q[$];
    int         tag_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         step_no  = 0;

    always #5 clock = ~clock;

    router_fsm dut (
        .clock            (clock),
        .resetn           (resetn),
        .pkt_valid        (pkt_valid),
        .data_in          (data_in),
        .fifo_full        (fifo_full),
        .fifo_empty_0     (fe[0]),
        .fifo_empty_1     (fe[1]),
        .fifo_empty_2     (fe[2]),
        .soft_reset_0     (sr[0]),
        .soft_reset_1     (sr[1]),
        .soft_reset_2     (sr[2]),
        .parity_done      (parity_done),
        .low_packet_valid (low_packet_valid),
        .detect_add       (detect_add),
        .lfd_state        (lfd_state),
        .ld_state         (ld_state),
        .laf_state        (laf_state),
        .full_state       (full_state),
        .rst_int_reg      (rst_int_reg),
        .write_enb_reg    (write_enb_reg),
        .busy             (busy)
    );

    // {detect_add, lfd, ld, laf, full, rst_int_reg, write_enb_reg, busy}
    function automatic logic [7:0] ov(input int s);
        case (s)
            S_DA:    return 8'b1000_0000;
            S_LFD:   return 8'b0100_0001;
            S_LD:    return 8'b0010_0010;
            S_LP:    return 8'b0000_0011;
            S_FF:    return 8'b0000_1001;
            S_LAF:   return 8'b0001_0011;
            S_CPE:   return 8'b0000_0101;
            default: return 8'b0000_0001;
        endcase
    endfunction

    task automatic step(input logic rn, input logic pv, input logic [1:0] din,
                        input logic ff, input logic [2:0] emp, input logic [2:0] srs,
                        input logic pd, input logic lpv, input int exp_state);
        resetn           = rn;
        pkt_valid        = pv;
        data_in          = din;
        fifo_full        = ff;
        fe               = emp;
        sr               = srs;
        parity_done      = pd;
        low_packet_valid = lpv;
        step_no++;
        exp_q.push_back(ov(exp_state));
        tag_q.push_back(step_no);
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            logic [7:0] act, exp_v;
            int         tag;
            exp_v = exp_q.pop_front();
            tag   = tag_q.pop_front();
            act   = {detect_add, lfd_state, ld_state, laf_state, full_state,
                     rst_int_reg, write_enb_reg, busy};
            n_checks++;
            if (act === exp_v) n_pass++;
            else $display("FAIL step%0d outputs: got %b expected %b", tag, act, exp_v);
        end
    end

    initial begin
        // reset and idle
        step(0, 0, 2'b00, 0, 3'b111, 3'b000, 0, 0, S_DA);
        step(0, 0, 2'b00, 0, 3'b111, 3'b000, 0, 0, S_DA);
        step(1, 0, 2'b00, 0, 3'b111, 3'b000, 0, 0, S_DA);
        step(1, 0, 2'b01, 0, 3'b111, 3'b000, 0, 0, S_DA);

        // normal packet to port 1: DA LFD LDx4 LP CPE DA
        step(1, 1, 2'b01, 0, 3'b111, 3'b000, 0, 0, S_LFD);
        step(1, 1, 2'b10, 0, 3'b111, 3'b000, 0, 0, S_LD);
        step(1, 1, 2'b11, 0, 3'b111, 3'b000, 0, 0, S_LD);
        step(1, 1, 2'b00, 0, 3'b111, 3'b000, 0, 0, S_LD);
        step(1, 1, 2'b01, 0, 3'b111, 3'b000, 0, 0, S_LD);
        step(1, 0, 2'b01, 0, 3'b111, 3'b000, 0, 0, S_LP);
        step(1, 0, 2'b01, 0, 3'b111, 3'b000, 0, 0, S_CPE);
        step(1, 0, 2'b01, 0, 3'b111, 3'b000, 0, 0, S_DA);

        // destination 2 busy for 6 cycles; data_in=0 meanwhile with port 0 empty
        step(1, 1, 2'b10, 0, 3'b011, 3'b000, 0, 0, S_WTE);
        for (int i = 0; i < 5; i++)
            step(1, 1, 2'b00, 0, 3'b011, 3'b000, 0, 0, S_WTE);
        step(1, 1, 2'b00, 0, 3'b111, 3'b000, 0, 0, S_LFD);
        step(1, 1, 2'b00, 0, 3'b111, 3'b000, 0, 0, S_LD);
        step(1, 0, 2'b00, 0, 3'b111, 3'b000, 0, 0, S_LP);
        step(1, 0, 2'b00, 0, 3'b111, 3'b000, 0, 0, S_CPE);
        step(1, 0, 2'b00, 0, 3'b111, 3'b000, 0, 0, S_DA);

        // FIFO full mid-payload, then low_packet_valid -> LP
        step(1, 1, 2'b00, 0, 3'b111, 3'b000, 0, 0, S_LFD);
        step(1, 1, 2'b00, 0, 3'b111, 3'b000, 0, 0, S_LD);
        step(1, 1, 2'b00, 1, 3'b111, 3'b000, 0, 0, S_FF);
        step(1, 1, 2'b00, 1, 3'b111, 3'b000, 0, 0, S_FF);
        step(1, 1, 2'b00, 1, 3'b111, 3'b000, 0, 0, S_FF);
        step(1, 0, 2'b00, 0, 3'b111, 3'b000, 0, 0, S_LAF);
        step(1, 0, 2'b00, 0, 3'b111, 3'b000, 0, 1, S_LP);
        step(1, 0, 2'b00, 0, 3'b111, 3'b000, 0, 0, S_CPE);
        step(1, 0, 2'b00, 0, 3'b111, 3'b000, 0, 0, S_DA);

        // full beats !pkt_valid; LAF -> LD; CPE full -> FF; LAF parity_done -> DA
        step(1, 1, 2'b00, 0, 3'b111, 3'b000, 0, 0, S_LFD);
        step(1, 1, 2'b00, 0, 3'b111, 3'b000, 0, 0, S_LD);
        step(1, 0, 2'b00, 1, 3'b111, 3'b000, 0, 0, S_FF);
        step(1, 1, 2'b00, 0, 3'b111, 3'b000, 0, 0, S_LAF);
        step(1, 1, 2'b00, 0, 3'b111, 3'b000, 0, 0, S_LD);
        step(1, 0, 2'b00, 0, 3'b111, 3'b000, 0, 0, S_LP);
        step(1, 0, 2'b00, 0, 3'b111, 3'b000, 0, 0, S_CPE);
        step(1, 0, 2'b00, 1, 3'b111, 3'b000, 0, 0, S_FF);
        step(1, 0, 2'b00, 0, 3'b111, 3'b000, 0, 0, S_LAF);
        step(1, 0, 2'b00, 0, 3'b111, 3'b000, 1, 1, S_DA);

        // soft reset: other port ignored, own port aborts
        step(1, 1, 2'b00, 0, 3'b111, 3'b000, 0, 0, S_LFD);
        step(1, 1, 2'b00, 0, 3'b111, 3'b000, 0, 0, S_LD);
        step(1, 1, 2'b00, 0, 3'b111, 3'b100, 0, 0, S_LD);
        step(1, 1, 2'b00, 0, 3'b111, 3'b001, 0, 0, S_DA);
        step(1, 0, 2'b00, 0, 3'b111, 3'b001, 0, 0, S_DA);

        // invalid address
        for (int i = 0; i < 4; i++)
            step(1, 1, 2'b11, 0, 3'b111, 3'b000, 0, 0, S_DA);

        // reset mid-packet
        step(1, 1, 2'b01, 0, 3'b111, 3'b000, 0, 0, S_LFD);
        step(1, 1, 2'b01, 0, 3'b111, 3'b000, 0, 0, S_LD);
        step(0, 1, 2'b01, 0, 3'b111, 3'b000, 0, 0, S_DA);
        step(1, 0, 2'b01, 0, 3'b111, 3'b000, 0, 0, S_DA);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
        @(negedge clock);
        #1;
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
